alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Command sequencer in front of the 16-bit ALU datapath (arithmetic/logic/compare/shift units, registered outputs, per-unit valid flags).
- Accepts one operation at a time over a valid/ready command interface.
- Drives the ALU operand/function inputs from registers and waits for the selected unit's flag.
- Selects that unit's result and returns it over a valid/ready response interface, with timeout error and completion counter.
- Sits between the system control FSM (UART command decoder side) and the ALU.

Parameters:
WIDTH, 16, operand/result width
TIMEOUT, 8, max EXEC cycles to wait for unit flag before error (>=2)
CNT_W, 8, width of completed-operation counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept command
cmd_func  input  4  ALU function; [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift), [1:0] op
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
alu_a  output  WIDTH  registered operand A to ALU
alu_b  output  WIDTH  registered operand B to ALU
alu_func  output  4  registered function to ALU
arith_out, logic_out, cmp_out, shift_out  input  WIDTH each  ALU unit results
carry_out  input  1  ALU arithmetic carry
arith_flag, logic_flag, cmp_flag, shift_flag  input  1 each  ALU unit valid flags
res_valid  output  1  response present
res_ready  input  1  consumer accepts response
res_data  output  WIDTH  selected unit result
res_carry  output  1  carry_out if arith op, else 0
res_err  output  1  timeout: flag never seen
busy  output  1  high in EXEC or RESP
op_count  output  CNT_W  completed responses (handshakes), wraps

Behaviour:
- Reset (rst=0, async): state IDLE; alu_a/alu_b/alu_func=0; res_data=0, res_carry=0, res_err=0, res_valid=0; op_count=0; wait counter=0. An in-flight command is dropped; no response issued.
- FSM states IDLE, EXEC, RESP; all outputs registered except cmd_ready (=1 iff state==IDLE) and busy (=state!=IDLE).
- IDLE: on cmd_valid&cmd_ready at an edge: alu_a<=cmd_a, alu_b<=cmd_b, alu_func<=cmd_func, unit select latched from cmd_func[3:2], wait counter<=0, go EXEC.
- EXEC: counter increments every cycle. Flag of latched unit ignored while counter==0 (ALU outputs still stale). When counter>=1 and selected flag=1: res_data<=selected unit result, res_carry<=carry_out if unit==arith else 0, res_err<=0, res_valid<=1, go RESP. Flags of non-selected units ignored.
- Timeout: counter reaches TIMEOUT-1 with selected flag still 0 -> res_data<=0, res_carry<=0, res_err<=1, res_valid<=1, go RESP.
- Latency: nominal response res_valid rises 2 edges after accepting edge.
- RESP: res_valid, res_data, res_carry, res_err held stable while res_ready=0. On res_ready=1: res_valid<=0, op_count<=op_count+1 (wraps max->0, counts error responses too), go IDLE.
- cmd_ready=0 in RESP even if res_ready=1: one-cycle bubble minimum between responses and next accept.
- alu_a/alu_b/alu_func hold last command values in IDLE/RESP; they change only on command accept.
- Command inputs ignored outside IDLE; res_ready ignored outside RESP.

Test Plan:
- Reset then cmd_func=4'b0000, a=5, b=7, res_ready=1 -> alu_func=0000 one edge after accept; res_valid on 2nd edge; res_data=12, res_carry=0, res_err=0; op_count=1.
- Arith add a=16'hFFFF, b=16'h0001 -> res_data=16'h0000, res_carry=1; then logic op 4'b0100 a=16'h00F0, b=16'h0FF0 -> res_data=16'h00F0, res_carry=0.
- Force selected flag low permanently, TIMEOUT=8 -> res_valid after 8 EXEC cycles with res_err=1, res_data=0; op_count increments on handshake.
- Hold res_ready=0 for 5 cycles in RESP, cmd_valid=1 throughout -> res_data/res_err stable, cmd_ready=0; after res_ready pulse, cmd_ready=1 next cycle, new command accepted.
- Assert rst low during EXEC -> all outputs to reset values immediately (async); no res_valid after release; op_count=0; next command completes normally.
- 256 back-to-back commands with CNT_W=8 -> op_count wraps 255->0.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command / response handshake bundle between the system
// control FSM and the ALU sequencer.
//   cmd_valid/cmd_ready : command handshake, cmd_func/cmd_a/cmd_b payload
//   res_valid/res_ready : response handshake, res_data/res_carry/res_err payload
// master = command issuer / response consumer, slave = sequencer.
`timescale 1ns/1ps
interface alu_sequencer_if #(
   parameter int WIDTH = 16
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_func;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_carry;
   logic             res_err;

   modport master (
      output cmd_valid, cmd_func, cmd_a, cmd_b, res_ready,
      input  cmd_ready, res_valid, res_data, res_carry, res_err
   );

   modport slave (
      input  cmd_valid, cmd_func, cmd_a, cmd_b, res_ready,
      output cmd_ready, res_valid, res_data, res_carry, res_err
   );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU command at a time, drives registered
// operands/function into the ALU, waits for the selected unit's valid flag
// (or times out) and returns the result over a response handshake.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-low reset
//   bus (slave)         : command/response handshake bundle
//   alu_a/alu_b/alu_func: registered operands and function to the ALU
//   *_out, carry_out    : ALU unit results and arithmetic carry
//   *_flag              : ALU per-unit valid flags
//   busy                : high while executing or holding a response
//   op_count            : completed response handshakes, wrapping
`timescale 1ns/1ps
module alu_sequencer #(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 8,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   alu_sequencer_if.slave   bus,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_func,
   input  logic [WIDTH-1:0] arith_out,
   input  logic [WIDTH-1:0] logic_out,
   input  logic [WIDTH-1:0] cmp_out,
   input  logic [WIDTH-1:0] shift_out,
   input  logic             carry_out,
   input  logic             arith_flag,
   input  logic             logic_flag,
   input  logic             cmp_flag,
   input  logic             shift_flag,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    wait_cnt;
   logic             sel_flag;
   logic [WIDTH-1:0] sel_res;
   logic             flag_hit;
   logic             timed_out;
   logic             res_valid_q;
   logic [WIDTH-1:0] res_data_q;
   logic             res_carry_q;
   logic             res_err_q;

   // Unit select lives in the registered function, so it stays latched
   // for the whole EXEC/RESP period.
   always_comb begin
      sel_flag = 1'b0;
      sel_res  = '0;
      case (alu_func[3:2])
         2'b00:   begin sel_flag = arith_flag; sel_res = arith_out; end
         2'b01:   begin sel_flag = logic_flag; sel_res = logic_out; end
         2'b10:   begin sel_flag = cmp_flag;   sel_res = cmp_out;   end
         default: begin sel_flag = shift_flag; sel_res = shift_out; end
      endcase
   end

   // First EXEC cycle still sees ALU outputs computed from the old operands.
   assign flag_hit  = (wait_cnt != '0) && sel_flag;
   assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.cmd_valid)          state_nxt = EXEC;
         EXEC:    if (flag_hit || timed_out)  state_nxt = RESP;
         RESP:    if (bus.res_ready)          state_nxt = IDLE;
         default:                             state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_ready = (state == IDLE);
      busy          = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_a       <= '0;
         alu_b       <= '0;
         alu_func    <= '0;
         wait_cnt    <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_carry_q <= 1'b0;
         res_err_q   <= 1'b0;
         op_count    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  alu_a    <= bus.cmd_a;
                  alu_b    <= bus.cmd_b;
                  alu_func <= bus.cmd_func;
                  wait_cnt <= '0;
               end
            end
            EXEC: begin
               wait_cnt <= wait_cnt + CW'(1);
               if (flag_hit) begin
                  res_data_q  <= sel_res;
                  res_carry_q <= (alu_func[3:2] == 2'b00) ? carry_out : 1'b0;
                  res_err_q   <= 1'b0;
                  res_valid_q <= 1'b1;
               end else if (timed_out) begin
                  res_data_q  <= '0;
                  res_carry_q <= 1'b0;
                  res_err_q   <= 1'b1;
                  res_valid_q <= 1'b1;
               end
            end
            RESP: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  op_count    <= op_count + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_carry = res_carry_q;
   assign bus.res_err   = res_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer with a registered ALU
// stub whose per-unit flags are gated by flag_en.
`timescale 1ns/1ps
module tb_alu_sequencer;

   logic        clk;
   logic        rst;
   logic [15:0] alu_a, alu_b;
   logic [3:0]  alu_func;
   logic [15:0] arith_out, logic_out, cmp_out, shift_out;
   logic        carry_out;
   logic        arith_flag, logic_flag, cmp_flag, shift_flag;
   logic        busy;
   logic [7:0]  op_count;
   logic [3:0]  flag_en;

   int n_checks = 0;
   int n_err    = 0;

   alu_sequencer_if #(.WIDTH(16)) bus ();

   alu_sequencer #(.WIDTH(16), .TIMEOUT(8), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_func   (alu_func),
      .arith_out  (arith_out),
      .logic_out  (logic_out),
      .cmp_out    (cmp_out),
      .shift_out  (shift_out),
      .carry_out  (carry_out),
      .arith_flag (arith_flag),
      .logic_flag (logic_flag),
      .cmp_flag   (cmp_flag),
      .shift_flag (shift_flag),
      .busy       (busy),
      .op_count   (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU stub: registered outputs one cycle after operands, flags follow flag_en.
   always_ff @(posedge clk) begin
      if (alu_func[1:0] == 2'b01) {carry_out, arith_out} <= {1'b0, alu_a} - {1'b0, alu_b};
      else                        {carry_out, arith_out} <= {1'b0, alu_a} + {1'b0, alu_b};
      case (alu_func[1:0])
         2'b00:   logic_out <= alu_a & alu_b;
         2'b01:   logic_out <= alu_a | alu_b;
         default: logic_out <= alu_a ^ alu_b;
      endcase
      cmp_out    <= {15'b0, (alu_a < alu_b)};
      shift_out  <= alu_a << alu_b[3:0];
      arith_flag <= flag_en[0];
      logic_flag <= flag_en[1];
      cmp_flag   <= flag_en[2];
      shift_flag <= flag_en[3];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_cmd(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                          output int lat);
      int w;
      bus.cmd_func  = f;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_valid = 1'b1;
      w = 0;
      while (!bus.cmd_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      lat = 0;
      while (!bus.res_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      int w;
      int bad;
      logic seen;

      rst = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_func  = '0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.res_ready = 1'b0;
      flag_en       = 4'hF;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_data",  bus.res_data, 0);
      check("rst_res_err",   bus.res_err, 0);
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_busy",      busy, 0);
      check("rst_op_count",  op_count, 0);
      check("rst_alu_func",  alu_func, 0);
      rst = 1'b1;

      // Basic add with edge-accurate latency
      bus.res_ready = 1'b1;
      bus.cmd_func  = 4'b0000;
      bus.cmd_a     = 16'd5;
      bus.cmd_b     = 16'd7;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      check("t1_alu_a",     alu_a, 5);
      check("t1_alu_b",     alu_b, 7);
      check("t1_alu_func",  alu_func, 0);
      check("t1_busy",      busy, 1);
      check("t1_cmd_ready", bus.cmd_ready, 0);
      @(posedge clk); #1;
      check("t1_valid_edge1", bus.res_valid, 0);
      @(posedge clk); #1;
      check("t1_valid_edge2", bus.res_valid, 1);
      check("t1_data",  bus.res_data, 12);
      check("t1_carry", bus.res_carry, 0);
      check("t1_err",   bus.res_err, 0);
      @(posedge clk); #1;
      check("t1_op_count",  op_count, 1);
      check("t1_valid_off", bus.res_valid, 0);
      check("t1_cmd_ready_after", bus.cmd_ready, 1);

      // Unit coverage with hand-computed results
      run_cmd(4'b0000, 16'hFFFF, 16'h0001, lat);
      check("add_ovf_lat",   lat, 2);
      check("add_ovf_data",  bus.res_data, 16'h0000);
      check("add_ovf_carry", bus.res_carry, 1);
      run_cmd(4'b0100, 16'h00F0, 16'h0FF0, lat);
      check("and_data",  bus.res_data, 16'h00F0);
      check("and_carry", bus.res_carry, 0);
      run_cmd(4'b0101, 16'hFF00, 16'h0F0F, lat);
      check("or_data",   bus.res_data, 16'hFF0F);
      check("or_carry_masked", bus.res_carry, 0);
      run_cmd(4'b0001, 16'h0010, 16'h0003, lat);
      check("sub_data",  bus.res_data, 16'h000D);
      run_cmd(4'b1000, 16'h0003, 16'h0009, lat);
      check("cmp_data",  bus.res_data, 16'h0001);
      run_cmd(4'b1100, 16'h0001, 16'h0004, lat);
      check("shl_data",  bus.res_data, 16'h0010);
      check("shl_lat",   lat, 2);

      // Timeout: arith flag held low, others high
      flag_en = 4'b1110;
      run_cmd(4'b0000, 16'h1234, 16'h1111, lat);
      check("to_lat",   lat, 8);
      check("to_err",   bus.res_err, 1);
      check("to_data",  bus.res_data, 0);
      check("to_carry", bus.res_carry, 0);
      check("to_count_before", op_count, 7);
      @(posedge clk); #1;
      check("to_count_after", op_count, 8);
      flag_en = 4'hF;

      // Response stall with a pending command
      bus.res_ready = 1'b0;
      bus.cmd_func  = 4'b0110;
      bus.cmd_a     = 16'h00FF;
      bus.cmd_b     = 16'h0F0F;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_func  = 4'b0001;
      bus.cmd_a     = 16'hAAAA;
      bus.cmd_b     = 16'h5555;
      w = 0;
      while (!bus.res_valid && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      check("stall_valid", bus.res_valid, 1);
      check("stall_data0", bus.res_data, 16'h0FF0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("stall_hold_valid", bus.res_valid, 1);
         check("stall_hold_data",  bus.res_data, 16'h0FF0);
         check("stall_hold_err",   bus.res_err, 0);
         check("stall_cmd_ready",  bus.cmd_ready, 0);
         check("stall_alu_a",      alu_a, 16'h00FF);
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      check("stall_release_ready", bus.cmd_ready, 1);
      check("stall_release_valid", bus.res_valid, 0);
      check("stall_release_count", op_count, 9);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      check("stall_next_alu_a",    alu_a, 16'hAAAA);
      check("stall_next_alu_func", alu_func, 4'b0001);
      w = 0;
      while (!bus.res_valid && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      check("stall_next_data", bus.res_data, 16'h5555);
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      check("stall_next_count", op_count, 10);

      // Asynchronous reset during EXEC
      bus.cmd_func  = 4'b0000;
      bus.cmd_a     = 16'h0001;
      bus.cmd_b     = 16'h0002;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      check("arst_busy_before", busy, 1);
      rst = 1'b0;
      #1;
      check("arst_alu_a",     alu_a, 0);
      check("arst_alu_func",  alu_func, 0);
      check("arst_busy",      busy, 0);
      check("arst_cmd_ready", bus.cmd_ready, 1);
      check("arst_op_count",  op_count, 0);
      check("arst_res_data",  bus.res_data, 0);
      #2;
      rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (bus.res_valid) seen = 1'b1;
      end
      check("arst_no_resp", seen, 0);
      run_cmd(4'b0000, 16'h0100, 16'h0023, lat);
      check("arst_next_lat",  lat, 2);
      check("arst_next_data", bus.res_data, 16'h0123);
      @(posedge clk); #1;
      check("arst_next_count", op_count, 1);

      // Counter wrap over 256 completed operations
      bad = 0;
      for (int i = 0; i < 254; i++) begin
         run_cmd(4'b0000, 16'(i), 16'h0001, lat);
         if (bus.res_data !== 16'(i + 1) || lat != 2) bad++;
      end
      check("wrap_data_errs", bad, 0);
      @(posedge clk); #1;
      check("wrap_count_255", op_count, 255);
      run_cmd(4'b0000, 16'h0000, 16'h0000, lat);
      @(posedge clk); #1;
      check("wrap_count_0", op_count, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
